// File: rtl/if1_fetch_buffer.sv
// IF1->ID fetch buffer: credit-gated icache issue, in-order PC tag check,
// line realignment by PC offset, stale-response dropping after flush.
module if1_fetch_buffer #(
  parameter int unsigned FETCH_W      = 2,
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned MAX_INFLIGHT = 2,
  parameter logic [31:0] INST_NOP     = 32'h0340_0000
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 flush,
  input  logic [31:0]          req_pc,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 rsp_valid,
  input  logic [31:0]          rsp_pc,
  input  logic [31:0]          rsp_pc_next,
  input  logic                 rsp_taken,
  input  logic [FETCH_W*32-1:0] rsp_inst,
  input  logic [31:0]          rsp_badv,
  input  logic [6:0]           rsp_excp,
  input  logic [1:0]           rsp_excp_flag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_pc,
  output logic [31:0]          out_pc_next,
  output logic                 out_taken,
  output logic [FETCH_W*32-1:0] out_inst,
  output logic [FETCH_W-1:0]   out_mask,
  output logic [31:0]          out_badv,
  output logic [6:0]           out_excp,
  output logic [1:0]           out_excp_flag,
  output logic                 pc_mismatch,
  output logic                 err_unexpected
);

  localparam int unsigned OFF_W  = (FETCH_W > 1) ? $clog2(FETCH_W) : 1;
  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;
  localparam int unsigned IF_W   = $clog2(MAX_INFLIGHT) + 1;
  localparam int unsigned TAG_W  = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;
  localparam int unsigned SUM_W  = ((CNT_W > IF_W) ? CNT_W : IF_W) + 1;
  localparam int unsigned INST_W = FETCH_W * 32;

  typedef struct packed {
    logic [31:0]        pc;
    logic [31:0]        pc_next;
    logic               taken;
    logic [INST_W-1:0]  inst;
    logic [FETCH_W-1:0] mask;
    logic [31:0]        badv;
    logic [6:0]         excp;
    logic [1:0]         flag;
  } entry_t;

  entry_t             fifo_q [DEPTH];
  entry_t             fifo_d [DEPTH];
  logic [31:0]        tag_q  [MAX_INFLIGHT];
  logic [31:0]        tag_d  [MAX_INFLIGHT];
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [IF_W-1:0]    inflight_q, inflight_d, drop_cnt_q, drop_cnt_d;
  logic [TAG_W-1:0]   tag_rd_q, tag_rd_d, tag_wr_q, tag_wr_d;
  logic               pc_mismatch_q, pc_mismatch_d;
  logic               err_unexpected_q, err_unexpected_d;

  logic               issue, rsp_drop, rsp_acc, rsp_unexp, tag_hit, wr, pop;
  logic [OFF_W-1:0]   off;
  logic [31:0]        lane;
  logic               lane_ok;
  entry_t             new_entry;
  entry_t             head;

  // Credit check uses registered occupancy only; reset holds it low.
  always_comb begin
    req_ready = rstn && !flush
             && (SUM_W'(count_q) + SUM_W'(inflight_q) < SUM_W'(DEPTH))
             && (SUM_W'(inflight_q) + SUM_W'(drop_cnt_q) < SUM_W'(MAX_INFLIGHT));
    out_valid = (count_q != '0);
    issue     = req_valid && req_ready;
    rsp_drop  = rsp_valid && (drop_cnt_q != '0);
    rsp_acc   = rsp_valid && (drop_cnt_q == '0) && (inflight_q != '0);
    rsp_unexp = rsp_valid && (drop_cnt_q == '0) && (inflight_q == '0);
    tag_hit   = (rsp_pc == tag_q[tag_rd_q]);
    wr        = rsp_acc && tag_hit && !flush;
    pop       = out_valid && out_ready && !flush;
  end

  // Shift the line down by the PC's lane offset; lanes past the line end are NOPs.
  always_comb begin
    new_entry         = '0;
    new_entry.pc      = rsp_pc;
    new_entry.pc_next = rsp_pc_next;
    new_entry.taken   = rsp_taken;
    off               = rsp_pc[OFF_W+1:2];
    lane              = INST_NOP;
    lane_ok           = 1'b0;
    for (int unsigned i = 0; i < FETCH_W; i++) begin
      lane    = INST_NOP;
      lane_ok = 1'b0;
      for (int unsigned j = 0; j < FETCH_W; j++) begin
        if (j == i + 32'(off)) begin
          lane    = rsp_inst[j*32 +: 32];
          lane_ok = 1'b1;
        end
      end
      new_entry.inst[i*32 +: 32] = lane;
      new_entry.mask[i]          = lane_ok;
    end
    if (rsp_excp_flag != 2'b00) begin
      new_entry.mask = FETCH_W'(1);
      new_entry.flag = 2'b11;
      new_entry.badv = rsp_badv;
      new_entry.excp = rsp_excp;
    end
  end

  // Next-state for FIFO, tag queue and counters; flush overrides everything.
  always_comb begin
    fifo_d           = fifo_q;
    tag_d            = tag_q;
    rd_ptr_d         = rd_ptr_q;
    wr_ptr_d         = wr_ptr_q;
    count_d          = count_q;
    inflight_d       = inflight_q;
    drop_cnt_d       = drop_cnt_q;
    tag_rd_d         = tag_rd_q;
    tag_wr_d         = tag_wr_q;
    pc_mismatch_d    = 1'b0;
    err_unexpected_d = err_unexpected_q;
    if (flush) begin
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      inflight_d = '0;
      tag_rd_d   = '0;
      tag_wr_d   = '0;
      drop_cnt_d = drop_cnt_q + inflight_q
                 - IF_W'(rsp_valid && ((inflight_q | drop_cnt_q) != '0));
    end else begin
      if (issue) begin
        tag_d[tag_wr_q] = req_pc;
        tag_wr_d = (tag_wr_q == TAG_W'(MAX_INFLIGHT - 1)) ? '0 : tag_wr_q + TAG_W'(1);
      end
      if (rsp_drop) begin
        drop_cnt_d = drop_cnt_q - IF_W'(1);
      end
      if (rsp_acc) begin
        tag_rd_d = (tag_rd_q == TAG_W'(MAX_INFLIGHT - 1)) ? '0 : tag_rd_q + TAG_W'(1);
        pc_mismatch_d = !tag_hit;
      end
      if (rsp_unexp) begin
        err_unexpected_d = 1'b1;
      end
      if (wr) begin
        fifo_d[wr_ptr_q] = new_entry;
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d    = count_q + CNT_W'(wr) - CNT_W'(pop);
      inflight_d = inflight_q + IF_W'(issue) - IF_W'(rsp_acc);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < DEPTH; i++) fifo_q[i] <= '0;
      for (int unsigned i = 0; i < MAX_INFLIGHT; i++) tag_q[i] <= '0;
      rd_ptr_q         <= '0;
      wr_ptr_q         <= '0;
      count_q          <= '0;
      inflight_q       <= '0;
      drop_cnt_q       <= '0;
      tag_rd_q         <= '0;
      tag_wr_q         <= '0;
      pc_mismatch_q    <= 1'b0;
      err_unexpected_q <= 1'b0;
    end else begin
      fifo_q           <= fifo_d;
      tag_q            <= tag_d;
      rd_ptr_q         <= rd_ptr_d;
      wr_ptr_q         <= wr_ptr_d;
      count_q          <= count_d;
      inflight_q       <= inflight_d;
      drop_cnt_q       <= drop_cnt_d;
      tag_rd_q         <= tag_rd_d;
      tag_wr_q         <= tag_wr_d;
      pc_mismatch_q    <= pc_mismatch_d;
      err_unexpected_q <= err_unexpected_d;
    end
  end

  // Head entry presented to decode; empty buffer shows NOPs and zeroed fields.
  always_comb begin
    head = fifo_q[rd_ptr_q];
    if (out_valid) begin
      out_pc        = head.pc;
      out_pc_next   = head.pc_next;
      out_taken     = head.taken;
      out_inst      = head.inst;
      out_mask      = head.mask;
      out_badv      = head.badv;
      out_excp      = head.excp;
      out_excp_flag = head.flag;
    end else begin
      out_pc        = '0;
      out_pc_next   = '0;
      out_taken     = 1'b0;
      out_inst      = {FETCH_W{INST_NOP}};
      out_mask      = '0;
      out_badv      = '0;
      out_excp      = '0;
      out_excp_flag = '0;
    end
    pc_mismatch    = pc_mismatch_q;
    err_unexpected = err_unexpected_q;
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rstn)
    !(wr && (count_q == CNT_W'(DEPTH))));

endmodule

// File: tb/tb_if1_fetch_buffer.sv
// Bench for if1_fetch_buffer: realignment vector table plus hand sequences for
// credit, flush dropping, tag mismatch and async reset; scoreboard checks decode output.
module tb_if1_fetch_buffer;

  localparam int unsigned FETCH_W = 2;
  localparam logic [31:0] NOP = 32'h0340_0000;
  localparam logic [31:0] IA = 32'hAAAA_0001;
  localparam logic [31:0] IB = 32'hBBBB_0002;
  localparam logic [31:0] IC = 32'hCCCC_0003;
  localparam logic [31:0] ID = 32'hDDDD_0004;

  logic        clk, rstn, flush, req_valid, req_ready, rsp_valid, rsp_taken;
  logic [31:0] req_pc, rsp_pc, rsp_pc_next, rsp_badv;
  logic [63:0] rsp_inst, out_inst;
  logic [6:0]  rsp_excp, out_excp;
  logic [1:0]  rsp_excp_flag, out_excp_flag, out_mask;
  logic        out_valid, out_ready, out_taken, pc_mismatch, err_unexpected;
  logic [31:0] out_pc, out_pc_next, out_badv;

  if1_fetch_buffer #(.FETCH_W(2), .DEPTH(4), .MAX_INFLIGHT(2), .INST_NOP(NOP)) dut (
    .clk(clk), .rstn(rstn), .flush(flush),
    .req_pc(req_pc), .req_valid(req_valid), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_pc(rsp_pc), .rsp_pc_next(rsp_pc_next),
    .rsp_taken(rsp_taken), .rsp_inst(rsp_inst), .rsp_badv(rsp_badv),
    .rsp_excp(rsp_excp), .rsp_excp_flag(rsp_excp_flag),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_pc_next(out_pc_next), .out_taken(out_taken), .out_inst(out_inst),
    .out_mask(out_mask), .out_badv(out_badv), .out_excp(out_excp),
    .out_excp_flag(out_excp_flag), .pc_mismatch(pc_mismatch),
    .err_unexpected(err_unexpected)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [63:0] inst;
    logic [1:0]  flag;
    logic [6:0]  excp;
    logic [63:0] exp_inst;
    logic [1:0]  exp_mask;
    logic [1:0]  exp_flag;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic        taken;
    logic [63:0] inst;
    logic [1:0]  mask;
    logic [1:0]  flag;
    logic [6:0]  excp;
    logic [31:0] badv;
  } exp_t;

  vec_t        vecs [6];
  exp_t        sb [$];
  exp_t        mon_e;
  int          checks = 0;
  int          errors = 0;
  logic [63:0] nop2;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Holds req_valid until accepted, bounded.
  task automatic issue(input logic [31:0] pc);
    logic got;
    got = 1'b0;
    req_pc = pc;
    req_valid = 1'b1;
    for (int n = 0; n < 20 && !got; n++) begin
      #2;
      got = req_ready;
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL issue_timeout pc=%h actual=0 expected=1", pc);
    end
  endtask

  task automatic respond(input logic [31:0] pc, input logic [63:0] inst,
                         input logic [1:0] flag, input logic [6:0] excp, input bit taken);
    rsp_valid = 1'b1;
    rsp_pc = pc;
    rsp_pc_next = pc + 32'd8;
    rsp_taken = taken;
    rsp_inst = inst;
    rsp_excp_flag = flag;
    rsp_excp = excp;
    rsp_badv = pc ^ 32'hFFFF_0000;
    tick();
    rsp_valid = 1'b0;
    rsp_excp_flag = 2'b00;
  endtask

  task automatic push_exp(input logic [31:0] pc, input bit taken, input logic [63:0] inst,
                          input logic [1:0] mask, input logic [1:0] flag, input logic [6:0] excp);
    exp_t e;
    e.pc = pc;
    e.pc_next = pc + 32'd8;
    e.taken = taken;
    e.inst = inst;
    e.mask = mask;
    e.flag = flag;
    e.excp = excp;
    e.badv = pc ^ 32'hFFFF_0000;
    sb.push_back(e);
  endtask

  task automatic run_vec(input int k);
    issue(vecs[k].pc);
    push_exp(vecs[k].pc, bit'(k[0]), vecs[k].exp_inst, vecs[k].exp_mask,
             vecs[k].exp_flag, vecs[k].excp);
    respond(vecs[k].pc, vecs[k].inst, vecs[k].flag, vecs[k].excp, bit'(k[0]));
  endtask

  // Scoreboard: compare the head each time decode consumes it.
  always @(negedge clk) begin
    if (rstn && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected_out actual_pc=%h expected=none", out_pc);
      end else begin
        mon_e = sb.pop_front();
        chk("out_pc", 64'(out_pc), 64'(mon_e.pc));
        chk("out_pc_next", 64'(out_pc_next), 64'(mon_e.pc_next));
        chk("out_taken", 64'(out_taken), 64'(mon_e.taken));
        chk("out_inst", out_inst, mon_e.inst);
        chk("out_mask", 64'(out_mask), 64'(mon_e.mask));
        chk("out_excp_flag", 64'(out_excp_flag), 64'(mon_e.flag));
        if (mon_e.flag != 2'b00) begin
          chk("out_excp", 64'(out_excp), 64'(mon_e.excp));
          chk("out_badv", 64'(out_badv), 64'(mon_e.badv));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    nop2 = {NOP, NOP};
    vecs[0] = '{32'h1c00_0000, {IB, IA}, 2'b00, 7'h00, {IB, IA},  2'b11, 2'b00};
    vecs[1] = '{32'h1c00_0004, {IB, IA}, 2'b00, 7'h00, {NOP, IB}, 2'b01, 2'b00};
    vecs[2] = '{32'h1c00_0008, {ID, IC}, 2'b00, 7'h00, {ID, IC},  2'b11, 2'b00};
    vecs[3] = '{32'h1c00_000c, {ID, IC}, 2'b01, 7'h08, {NOP, ID}, 2'b01, 2'b11};
    vecs[4] = '{32'h1c00_0010, {ID, IC}, 2'b10, 7'h0c, {ID, IC},  2'b01, 2'b11};
    vecs[5] = '{32'h1c00_0014, {IA, IC}, 2'b00, 7'h00, {NOP, IA}, 2'b01, 2'b00};

    rstn = 1'b0; flush = 1'b0; req_valid = 1'b0; req_pc = '0; out_ready = 1'b0;
    rsp_valid = 1'b0; rsp_pc = '0; rsp_pc_next = '0; rsp_taken = 1'b0;
    rsp_inst = '0; rsp_badv = '0; rsp_excp = '0; rsp_excp_flag = '0;
    #12;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_pc_mismatch", 64'(pc_mismatch), 64'd0);
    chk("rst_err_unexpected", 64'(err_unexpected), 64'd0);
    chk("rst_out_mask", 64'(out_mask), 64'd0);
    chk("rst_out_inst", out_inst, nop2);
    @(negedge clk);
    rstn = 1'b1;
    tick();
    chk("post_rst_req_ready", 64'(req_ready), 64'd1);

    // Realignment / exception table.
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      run_vec(k);
      #1;
      chk($sformatf("vec%0d_visible", k), 64'(out_valid), 64'd1);
    end
    tick();
    chk("table_drained", 64'(out_valid), 64'd0);
    chk("table_sb_empty", 64'(sb.size()), 64'd0);

    // Credit: stored entries plus in-flight requests never exceed DEPTH.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      issue(32'h2000_0000 + 32'(i * 8));
      push_exp(32'h2000_0000 + 32'(i * 8), 1'b0, {IB, IA}, 2'b11, 2'b00, 7'h00);
      respond(32'h2000_0000 + 32'(i * 8), {IB, IA}, 2'b00, 7'h00, 1'b0);
    end
    issue(32'h2000_0018);
    #1;
    chk("credit_inflight_ready", 64'(req_ready), 64'd0);
    push_exp(32'h2000_0018, 1'b0, {ID, IC}, 2'b11, 2'b00, 7'h00);
    respond(32'h2000_0018, {ID, IC}, 2'b00, 7'h00, 1'b0);
    #1;
    chk("credit_full_ready", 64'(req_ready), 64'd0);
    chk("credit_full_valid", 64'(out_valid), 64'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    #1;
    chk("credit_after_pop_ready", 64'(req_ready), 64'd1);
    out_ready = 1'b1;
    for (int n = 0; n < 10 && out_valid; n++) tick();
    chk("credit_drained", 64'(out_valid), 64'd0);
    chk("credit_sb_empty", 64'(sb.size()), 64'd0);

    // Flush with two requests owed: both responses dropped, next one stored.
    issue(32'h3000_0000);
    issue(32'h3000_0008);
    flush = 1'b1;
    #1;
    chk("flush_req_ready", 64'(req_ready), 64'd0);
    tick();
    flush = 1'b0;
    #1;
    chk("drop_credit_ready", 64'(req_ready), 64'd0);
    respond(32'h3000_0000, {IB, IA}, 2'b00, 7'h00, 1'b0);
    #1;
    chk("drop0_out_valid", 64'(out_valid), 64'd0);
    respond(32'h3000_0008, {IB, IA}, 2'b00, 7'h00, 1'b0);
    #1;
    chk("drop1_out_valid", 64'(out_valid), 64'd0);
    chk("drop_done_ready", 64'(req_ready), 64'd1);
    issue(32'h3000_0010);
    push_exp(32'h3000_0010, 1'b1, {ID, IC}, 2'b11, 2'b00, 7'h00);
    respond(32'h3000_0010, {ID, IC}, 2'b00, 7'h00, 1'b1);
    #1;
    chk("post_flush_store", 64'(out_valid), 64'd1);
    tick();

    // Flush coinciding with a response: only one response left to drop.
    issue(32'h3100_0000);
    issue(32'h3100_0008);
    flush = 1'b1;
    rsp_valid = 1'b1; rsp_pc = 32'h3100_0000; rsp_inst = {IB, IA};
    tick();
    flush = 1'b0;
    rsp_valid = 1'b0;
    #1;
    chk("flush_rsp_out_valid", 64'(out_valid), 64'd0);
    chk("flush_rsp_ready", 64'(req_ready), 64'd1);
    respond(32'h3100_0008, {IB, IA}, 2'b00, 7'h00, 1'b0);
    #1;
    chk("flush_rsp_drop_valid", 64'(out_valid), 64'd0);
    issue(32'h3100_0010);
    push_exp(32'h3100_0010, 1'b0, {IB, IA}, 2'b11, 2'b00, 7'h00);
    respond(32'h3100_0010, {IB, IA}, 2'b00, 7'h00, 1'b0);
    #1;
    chk("flush_rsp_store", 64'(out_valid), 64'd1);
    tick();

    // Tag mismatch and unexpected response.
    issue(32'h0000_00f8);
    respond(32'h0000_0100, {IB, IA}, 2'b00, 7'h00, 1'b0);
    #1;
    chk("mismatch_pulse", 64'(pc_mismatch), 64'd1);
    chk("mismatch_no_write", 64'(out_valid), 64'd0);
    tick();
    chk("mismatch_one_cycle", 64'(pc_mismatch), 64'd0);
    chk("err_before", 64'(err_unexpected), 64'd0);
    respond(32'h0000_0200, {IB, IA}, 2'b00, 7'h00, 1'b0);
    #1;
    chk("err_set", 64'(err_unexpected), 64'd1);
    tick();
    chk("err_sticky", 64'(err_unexpected), 64'd1);
    chk("unexp_no_mismatch", 64'(pc_mismatch), 64'd0);

    // Asynchronous reset with an entry held.
    out_ready = 1'b0;
    run_vec(3);
    #1;
    chk("pre_rst_valid", 64'(out_valid), 64'd1);
    rstn = 1'b0;
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_err", 64'(err_unexpected), 64'd0);
    chk("arst_req_ready", 64'(req_ready), 64'd0);
    chk("arst_out_mask", 64'(out_mask), 64'd0);
    chk("arst_out_flag", 64'(out_excp_flag), 64'd0);
    chk("arst_out_inst", out_inst, nop2);
    chk("arst_out_pc", 64'(out_pc), 64'd0);
    sb.delete();
    @(negedge clk);
    rstn = 1'b1;
    tick();
    out_ready = 1'b1;
    run_vec(0);
    tick();
    tick();
    chk("final_sb_empty", 64'(sb.size()), 64'd0);
    chk("final_out_valid", 64'(out_valid), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
